mul_wb: RTL and testbench
=========================

MUL_WB -- requirements
Module: mul_wb

Interface
REQ-001 SHALL have parameter TAG_DEPTH, default 2, meaning the number of outstanding multiply tags tracked (power of two, >=2).
REQ-002 SHALL have parameter OUT_DEPTH, default 2, meaning the number of writeback output buffer entries (power of two, >=2).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port req_fire  input  1  multiplier request handshake (req_valid && req_ready) this cycle.
REQ-006 SHALL have port req_rd  input  5  destination register of the request.
REQ-007 SHALL have port req_wb_en  input  1  request writes a register.
REQ-008 SHALL have port mul_result  input  64  multiplier response data.
REQ-009 SHALL have port mul_valid  input  1  multiplier response valid.
REQ-010 SHALL have port mul_ready  output  1  response accepted.
REQ-011 SHALL have port flush  input  1  pipeline kill of all in-flight multiplies.
REQ-012 SHALL have port wb_valid  output  1  writeback entry available.
REQ-013 SHALL have port wb_rd  output  5  writeback destination.
REQ-014 SHALL have port wb_data  output  64  writeback data.
REQ-015 SHALL have port wb_ready  input  1  writeback consumes entry.
REQ-016 SHALL have port busy  output  1  any tag or output entry occupied.
REQ-017 SHALL have port err  output  2  sticky errors: [0] tag overflow, [1] tag underflow.

Function
REQ-018 Tag FIFO SHALL store {rd, wb_en, killed} per entry; push on req_fire, pop on mul_valid && mul_ready; in-order.
REQ-019 Response handshake SHALL pair mul_result with the oldest tag.
REQ-020 Output FIFO push SHALL occur on response handshake only if tag not killed, wb_en=1, rd!=0; otherwise response is consumed and discarded.
REQ-021 mul_ready SHALL be 1 when output FIFO not full, or when the oldest tag will be discarded (killed, wb_en=0, or rd=0); combinational from state, not from wb_ready.
REQ-022 Latency: response handshake in cycle N SHALL give wb_valid=1 in cycle N+1 with that entry, if output FIFO was empty.
REQ-023 wb_valid SHALL equal output FIFO non-empty; wb_rd/wb_data SHALL be the head entry; pop on wb_valid && wb_ready.
REQ-024 Simultaneous output push and pop SHALL be legal at full occupancy only when a pop occurs that cycle is not required (mul_ready excludes it); at non-full, occupancy is unchanged.
REQ-025 Simultaneous tag push and pop SHALL be legal at any occupancy including full (occupancy unchanged).
REQ-026 flush SHALL set killed on every valid tag entry and empty the output FIFO in the same cycle.
REQ-027 flush coincident with req_fire SHALL mark the new tag killed; flush coincident with a response handshake SHALL discard that response.
REQ-028 req_fire with tag FIFO full and no pop SHALL drop the tag and set err[0]; mul_valid with empty tag FIFO SHALL keep mul_ready=1, discard the data, set err[1].
REQ-029 Pointers SHALL wrap modulo depth; full/empty SHALL be derived from a depth+1 occupancy counter.
REQ-030 busy SHALL be 1 whenever tag or output occupancy is non-zero.

Reset
REQ-031 On rst: both FIFOs empty, all killed bits 0, err=0, wb_valid=0, busy=0, mul_ready=1; FIFO data storage need not be reset.
REQ-032 rst asserted mid-operation SHALL abandon all entries immediately; first cycle after release behaves as empty.

Structure
REQ-033 Error bit indices and default depths SHALL live in the shared defines header beside the MO_* op codes.
REQ-034 One sub-module, sync_fifo (parameterised width/depth, push/pop/clear, full/empty), SHALL be instantiated for both FIFOs; killed bits held in mul_wb for parallel set.

Verification
REQ-035 req_fire rd=5; next cycle mul_valid, result 0x1234 -> cycle after: wb_valid=1, wb_rd=5, wb_data=0x1234.
REQ-036 Two tags rd=3,rd=4, wb_ready=0, two responses -> output full, mul_ready=0 on third response; release wb_ready -> rd 3 then 4 in order.
REQ-037 req_fire rd=7, flush, then response 0xFF -> mul_ready=1, wb_valid stays 0, busy falls to 0.
REQ-038 req_fire rd=0 (or wb_en=0), response -> consumed, no wb_valid.
REQ-039 Three req_fire without responses -> err=2'b01; mul_valid with empty tags -> err=2'b11.
REQ-040 rst asserted with one tag and one output entry -> all outputs at reset values same cycle.

Source files
------------

// File: rtl/mul_wb_pkg.sv
// rtl/mul_wb_pkg.sv - shared defines for the multiplier writeback block
// Holds the multiply op codes, the sticky error bit indices, the default
// FIFO depths and the packed entry formats used by mul_wb.
package mul_wb_pkg;

    typedef enum logic [1:0] {
        MO_MUL    = 2'd0,
        MO_MULH   = 2'd1,
        MO_MULHSU = 2'd2,
        MO_MULHU  = 2'd3
    } mo_op_e;

    localparam int ERR_W         = 2;
    localparam int ERR_TAG_OVF   = 0;
    localparam int ERR_TAG_UDF   = 1;

    localparam int DEF_TAG_DEPTH = 2;
    localparam int DEF_OUT_DEPTH = 2;

    typedef struct packed {
        logic [4:0] rd;
        logic       wb_en;
    } tag_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] data;
    } out_t;

    // A response is thrown away when its tag was flushed or it writes nothing.
    function automatic logic tag_discard(input logic killed, input tag_t tag);
        return killed || !tag.wb_en || (tag.rd == 5'd0);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with occupancy counter
// Ports: clk/rst (async active-high); push/push_data write, pop/pop_data
// read the head; clear empties in one cycle; full/empty status; wr_ptr and
// rd_ptr expose slot indices so a parent can keep side bits per entry.
// A push while full is accepted only if a pop happens the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     clear,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH)-1:0] wr_ptr,
    output logic [$clog2(DEPTH)-1:0] rd_ptr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign full     = (cnt_q == CNT_W'(DEPTH));
    assign empty    = (cnt_q == '0);
    assign pop_data = mem_q[rd_ptr_q];
    assign wr_ptr   = wr_ptr_q;
    assign rd_ptr   = rd_ptr_q;

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/mul_wb.sv
// rtl/mul_wb.sv - multiplier tag tracking and writeback buffer
// Ports: clk/rst (async active-high); req_fire/req_rd/req_wb_en record a
// tag per issued multiply; mul_result/mul_valid/mul_ready return results in
// order; flush kills all in-flight work; wb_valid/wb_rd/wb_data/wb_ready
// present buffered writebacks; busy flags any occupancy; err holds sticky
// tag overflow/underflow flags.
module mul_wb
    import mul_wb_pkg::*;
#(
    parameter int TAG_DEPTH = DEF_TAG_DEPTH,
    parameter int OUT_DEPTH = DEF_OUT_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_fire,
    input  logic [4:0]       req_rd,
    input  logic             req_wb_en,
    input  logic [63:0]      mul_result,
    input  logic             mul_valid,
    output logic             mul_ready,
    input  logic             flush,
    output logic             wb_valid,
    output logic [4:0]       wb_rd,
    output logic [63:0]      wb_data,
    input  logic             wb_ready,
    output logic             busy,
    output logic [ERR_W-1:0] err
);

    localparam int TPTR_W = $clog2(TAG_DEPTH);
    localparam int OPTR_W = $clog2(OUT_DEPTH);

    tag_t               tag_head;
    logic               tag_full, tag_empty;
    logic [TPTR_W-1:0]  tag_wr_ptr, tag_rd_ptr;
    out_t               out_head;
    out_t               out_push_data;
    logic               out_full, out_empty;
    logic [OPTR_W-1:0]  out_wr_ptr_unused, out_rd_ptr_unused;

    logic [TAG_DEPTH-1:0] killed_q, killed_d;
    logic [ERR_W-1:0]     err_q, err_d;

    logic head_discard;
    logic tag_pop;
    logic tag_push_ok;
    logic out_push;
    logic out_pop;

    always_comb begin
        head_discard  = tag_discard(killed_q[tag_rd_ptr], tag_head);
        // Empty tags keep ready high so stray responses are swallowed.
        mul_ready     = tag_empty || !out_full || head_discard;
        tag_pop       = mul_valid && mul_ready && !tag_empty;
        tag_push_ok   = req_fire && (!tag_full || tag_pop);
        out_push      = tag_pop && !head_discard && !flush;
        out_pop       = !out_empty && wb_ready;
        out_push_data = '{rd: tag_head.rd, data: mul_result};

        killed_d = killed_q;
        // Marking every slot is safe: a free slot's bit is rewritten on push.
        if (flush) killed_d = '1;
        if (tag_push_ok) killed_d[tag_wr_ptr] = flush;

        err_d = err_q;
        if (req_fire && tag_full && !tag_pop) err_d[ERR_TAG_OVF] = 1'b1;
        if (mul_valid && tag_empty)           err_d[ERR_TAG_UDF] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            killed_q <= '0;
            err_q    <= '0;
        end else begin
            killed_q <= killed_d;
            err_q    <= err_d;
        end
    end

    sync_fifo #(.WIDTH($bits(tag_t)), .DEPTH(TAG_DEPTH)) u_tag_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (req_fire),
        .push_data ({req_rd, req_wb_en}),
        .pop       (tag_pop),
        .clear     (1'b0),
        .pop_data  (tag_head),
        .full      (tag_full),
        .empty     (tag_empty),
        .wr_ptr    (tag_wr_ptr),
        .rd_ptr    (tag_rd_ptr)
    );

    sync_fifo #(.WIDTH($bits(out_t)), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (out_push),
        .push_data (out_push_data),
        .pop       (out_pop),
        .clear     (flush),
        .pop_data  (out_head),
        .full      (out_full),
        .empty     (out_empty),
        .wr_ptr    (out_wr_ptr_unused),
        .rd_ptr    (out_rd_ptr_unused)
    );

    assign wb_valid = !out_empty;
    assign wb_rd    = out_head.rd;
    assign wb_data  = out_head.data;
    assign busy     = !tag_empty || !out_empty;
    assign err      = err_q;

endmodule

// File: tb/tb_mul_wb.sv
// tb/tb_mul_wb.sv - directed self-checking bench for mul_wb
module tb_mul_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_fire;
    logic [4:0]  req_rd;
    logic        req_wb_en;
    logic [63:0] mul_result;
    logic        mul_valid;
    logic        mul_ready;
    logic        flush;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic        wb_ready;
    logic        busy;
    logic [1:0]  err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mul_wb #(.TAG_DEPTH(2), .OUT_DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_fire   (req_fire),
        .req_rd     (req_rd),
        .req_wb_en  (req_wb_en),
        .mul_result (mul_result),
        .mul_valid  (mul_valid),
        .mul_ready  (mul_ready),
        .flush      (flush),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .wb_ready   (wb_ready),
        .busy       (busy),
        .err        (err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        req_fire = 0; req_rd = 0; req_wb_en = 1; mul_valid = 0; mul_result = 0; flush = 0;
    endtask

    task automatic test_reset;
        rst = 1; idle(); wb_ready = 0;
        tick(); tick();
        checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL reset_wb_valid got=%0b exp=0", wb_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (mul_ready !== 1'b1) begin failures++; $display("FAIL reset_mul_ready got=%0b exp=1", mul_ready); end
        checks++; if (err !== 2'b00) begin failures++; $display("FAIL reset_err got=%b exp=00", err); end
        rst = 0;
        tick();
    endtask

    task automatic test_basic;
        wb_ready = 0;
        req_fire = 1; req_rd = 5;
        tick();
        idle(); mul_valid = 1; mul_result = 64'h1234;
        #1;
        checks++; if (mul_ready !== 1'b1 || wb_valid !== 1'b0) begin failures++; $display("FAIL basic_pre got ready=%0b valid=%0b exp ready=1 valid=0", mul_ready, wb_valid); end
        tick();
        idle();
        checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd5 || wb_data !== 64'h1234) begin failures++; $display("FAIL basic_wb got v=%0b rd=%0d d=%h exp v=1 rd=5 d=1234", wb_valid, wb_rd, wb_data); end
        wb_ready = 1;
        tick();
        checks++; if (wb_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL basic_drain got v=%0b busy=%0b exp 0 0", wb_valid, busy); end
    endtask

    task automatic test_backpressure;
        wb_ready = 0;
        req_fire = 1; req_rd = 3; tick();
        req_rd = 4; tick();
        idle(); mul_valid = 1; mul_result = 64'hA; tick();
        mul_result = 64'hB; tick();
        idle(); req_fire = 1; req_rd = 6; tick();
        idle(); mul_valid = 1; mul_result = 64'hC;
        #1;
        checks++; if (mul_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_full got=%0b exp=0", mul_ready); end
        mul_valid = 0; wb_ready = 1;
        #1;
        checks++; if (wb_rd !== 5'd3 || wb_data !== 64'hA) begin failures++; $display("FAIL bp_first got rd=%0d d=%h exp rd=3 d=a", wb_rd, wb_data); end
        tick();
        checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd4 || wb_data !== 64'hB) begin failures++; $display("FAIL bp_second got v=%0b rd=%0d d=%h exp v=1 rd=4 d=b", wb_valid, wb_rd, wb_data); end
        mul_valid = 1; mul_result = 64'hC;
        #1;
        checks++; if (mul_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_free got=%0b exp=1", mul_ready); end
        tick();
        idle();
        checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd6 || wb_data !== 64'hC) begin failures++; $display("FAIL bp_third got v=%0b rd=%0d d=%h exp v=1 rd=6 d=c", wb_valid, wb_rd, wb_data); end
        tick();
        checks++; if (wb_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL bp_drain got v=%0b busy=%0b exp 0 0", wb_valid, busy); end
    endtask

    task automatic test_flush;
        wb_ready = 0;
        req_fire = 1; req_rd = 7; tick();
        idle(); flush = 1; tick();
        idle(); mul_valid = 1; mul_result = 64'hFF;
        #1;
        checks++; if (mul_ready !== 1'b1) begin failures++; $display("FAIL flush_ready got=%0b exp=1", mul_ready); end
        tick();
        idle();
        checks++; if (wb_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL flush_killed got v=%0b busy=%0b exp 0 0", wb_valid, busy); end
        // flush empties an already buffered entry and kills a coincident request
        req_fire = 1; req_rd = 9; tick();
        idle(); mul_valid = 1; mul_result = 64'h99; tick();
        idle(); flush = 1; req_fire = 1; req_rd = 10; tick();
        checks++; if (wb_valid !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL flush_out got v=%0b busy=%0b exp v=0 busy=1", wb_valid, busy); end
        idle(); mul_valid = 1; mul_result = 64'h77; tick();
        idle();
        checks++; if (wb_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL flush_coinc got v=%0b busy=%0b exp 0 0", wb_valid, busy); end
    endtask

    task automatic test_discard;
        wb_ready = 0;
        req_fire = 1; req_rd = 0; tick();
        idle(); mul_valid = 1; mul_result = 64'h55; tick();
        idle();
        checks++; if (wb_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL disc_rd0 got v=%0b busy=%0b exp 0 0", wb_valid, busy); end
        req_fire = 1; req_rd = 8; req_wb_en = 0; tick();
        idle(); mul_valid = 1; mul_result = 64'h66; tick();
        idle();
        checks++; if (wb_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL disc_nowb got v=%0b busy=%0b exp 0 0", wb_valid, busy); end
        // output full but the head tag writes nothing: response still accepted
        req_fire = 1; req_rd = 20; tick();
        req_rd = 21; mul_valid = 1; mul_result = 64'hD1; tick();
        req_rd = 0; mul_result = 64'hD2; tick();
        idle(); mul_valid = 1; mul_result = 64'hD3;
        #1;
        checks++; if (mul_ready !== 1'b1) begin failures++; $display("FAIL disc_full_ready got=%0b exp=1", mul_ready); end
        tick();
        idle();
        checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd20 || wb_data !== 64'hD1) begin failures++; $display("FAIL disc_full_head got v=%0b rd=%0d d=%h exp v=1 rd=20 d=d1", wb_valid, wb_rd, wb_data); end
        wb_ready = 1; tick();
        checks++; if (wb_rd !== 5'd21 || wb_data !== 64'hD2) begin failures++; $display("FAIL disc_full_next got rd=%0d d=%h exp rd=21 d=d2", wb_rd, wb_data); end
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL disc_full_drain got busy=%0b exp=0", busy); end
    endtask

    task automatic test_back_to_back;
        wb_ready = 1;
        req_fire = 1; req_rd = 10; tick();
        req_rd = 11; tick();
        req_rd = 12; mul_valid = 1; mul_result = 64'h1; tick();
        checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd10 || wb_data !== 64'h1 || err !== 2'b00) begin failures++; $display("FAIL b2b_first got v=%0b rd=%0d d=%h err=%b exp v=1 rd=10 d=1 err=00", wb_valid, wb_rd, wb_data, err); end
        idle(); mul_valid = 1; mul_result = 64'h2; tick();
        checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd11 || wb_data !== 64'h2) begin failures++; $display("FAIL b2b_second got v=%0b rd=%0d d=%h exp v=1 rd=11 d=2", wb_valid, wb_rd, wb_data); end
        mul_result = 64'h3; tick();
        checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd12 || wb_data !== 64'h3) begin failures++; $display("FAIL b2b_third got v=%0b rd=%0d d=%h exp v=1 rd=12 d=3", wb_valid, wb_rd, wb_data); end
        idle(); tick();
        checks++; if (busy !== 1'b0 || err !== 2'b00) begin failures++; $display("FAIL b2b_end got busy=%0b err=%b exp busy=0 err=00", busy, err); end
    endtask

    task automatic test_errors;
        wb_ready = 1;
        req_fire = 1; req_rd = 1; tick(); tick(); tick();
        idle();
        checks++; if (err !== 2'b01) begin failures++; $display("FAIL err_ovf got=%b exp=01", err); end
        mul_valid = 1; mul_result = 64'h11; tick(); tick();
        idle(); tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL err_drain got busy=%0b exp=0", busy); end
        mul_valid = 1; mul_result = 64'h22;
        #1;
        checks++; if (mul_ready !== 1'b1) begin failures++; $display("FAIL err_udf_ready got=%0b exp=1", mul_ready); end
        tick();
        idle();
        checks++; if (err !== 2'b11 || wb_valid !== 1'b0) begin failures++; $display("FAIL err_udf got err=%b v=%0b exp err=11 v=0", err, wb_valid); end
    endtask

    task automatic test_reset_mid;
        wb_ready = 0;
        req_fire = 1; req_rd = 2; tick();
        req_rd = 3; mul_valid = 1; mul_result = 64'h42; tick();
        idle();
        checks++; if (wb_valid !== 1'b1 || busy !== 1'b1) begin failures++; $display("FAIL rmid_pre got v=%0b busy=%0b exp 1 1", wb_valid, busy); end
        #1; rst = 1; #1;
        checks++; if (wb_valid !== 1'b0 || busy !== 1'b0 || mul_ready !== 1'b1 || err !== 2'b00) begin failures++; $display("FAIL rmid_async got v=%0b busy=%0b rdy=%0b err=%b exp 0 0 1 00", wb_valid, busy, mul_ready, err); end
        tick();
        rst = 0;
        req_fire = 1; req_rd = 4; tick();
        idle(); mul_valid = 1; mul_result = 64'h44; tick();
        idle();
        checks++; if (wb_valid !== 1'b1 || wb_rd !== 5'd4 || wb_data !== 64'h44 || err !== 2'b00) begin failures++; $display("FAIL rmid_after got v=%0b rd=%0d d=%h err=%b exp v=1 rd=4 d=44 err=00", wb_valid, wb_rd, wb_data, err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_flush();
        test_discard();
        test_back_to_back();
        test_errors();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
